// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core and loader request/return signals plus the memory-macro port
interface dmem_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9
);
   logic              core_req;
   logic              core_we;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic              core_gnt;
   logic              core_rvalid;
   logic [DATA_W-1:0] core_rdata;
   logic              core_stall;
   logic              ld_req;
   logic              ld_we;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_wdata;
   logic              ld_lock;
   logic              ld_gnt;
   logic              ld_rvalid;
   logic [DATA_W-1:0] ld_rdata;
   logic              mem_wr;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wr_data;
   logic [DATA_W-1:0] mem_rd_data;

   modport slave (
      input  core_req, core_we, core_addr, core_wdata,
      input  ld_req, ld_we, ld_addr, ld_wdata, ld_lock, mem_rd_data,
      output core_gnt, core_rvalid, core_rdata, core_stall,
      output ld_gnt, ld_rvalid, ld_rdata,
      output mem_wr, mem_rd, mem_addr, mem_wr_data
   );

   modport master (
      output core_req, core_we, core_addr, core_wdata,
      output ld_req, ld_we, ld_addr, ld_wdata, ld_lock, mem_rd_data,
      input  core_gnt, core_rvalid, core_rdata, core_stall,
      input  ld_gnt, ld_rvalid, ld_rdata,
      input  mem_wr, mem_rd, mem_addr, mem_wr_data
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between core and loader with round-robin ties,
// a loader lock mode, tagged 1-cycle read return and a saturating core stall counter
module dmem_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   dmem_arbiter_if.slave    bus,
   output logic [CNT_W-1:0] stall_cnt
);
   typedef enum logic {RR, LOCK} state_t;
   typedef enum logic [1:0] {NONE, CORE, LD} owner_t;

   state_t state, state_nx;
   owner_t rd_owner, rd_owner_nx;
   logic   last_ld;
   logic   core_gnt, ld_gnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= RR;
         last_ld   <= 1'b1;
         rd_owner  <= NONE;
         stall_cnt <= '0;
      end else begin
         state    <= state_nx;
         rd_owner <= rd_owner_nx;
         if (core_gnt | ld_gnt) last_ld <= ld_gnt;
         if (bus.core_stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   // Grants are forced low while reset is held so nothing reaches the memory
   always_comb begin
      core_gnt = 1'b0;
      ld_gnt   = 1'b0;
      if (!reset) begin
         if (state == LOCK && bus.ld_lock) begin
            ld_gnt = bus.ld_req;
         end else begin
            core_gnt = bus.core_req & (~bus.ld_req | last_ld);
            ld_gnt   = bus.ld_req & ~core_gnt;
         end
      end
      state_nx    = (bus.ld_lock && (state == LOCK || ld_gnt)) ? LOCK : RR;
      rd_owner_nx = (core_gnt & ~bus.core_we) ? CORE :
                    (ld_gnt & ~bus.ld_we)     ? LD   : NONE;
   end

   assign bus.core_gnt    = core_gnt;
   assign bus.ld_gnt      = ld_gnt;
   assign bus.core_stall  = bus.core_req & ~core_gnt;
   assign bus.mem_wr      = (core_gnt & bus.core_we) | (ld_gnt & bus.ld_we);
   assign bus.mem_rd      = (core_gnt & ~bus.core_we) | (ld_gnt & ~bus.ld_we);
   assign bus.mem_addr    = core_gnt ? bus.core_addr  : ld_gnt ? bus.ld_addr  : ADDR_W'(0);
   assign bus.mem_wr_data = core_gnt ? bus.core_wdata : ld_gnt ? bus.ld_wdata : DATA_W'(0);
   assign bus.core_rvalid = rd_owner == CORE;
   assign bus.ld_rvalid   = rd_owner == LD;
   assign bus.core_rdata  = (rd_owner == CORE) ? bus.mem_rd_data : DATA_W'(0);
   assign bus.ld_rdata    = (rd_owner == LD)   ? bus.mem_rd_data : DATA_W'(0);
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter, with a behavioural memory
// and a second narrow-counter instance for stall counter saturation
module tb_dmem_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sreset = 1'b1;
   logic [15:0] stall_cnt;
   logic [3:0] sat_cnt;

   always #5 clk = ~clk;

   dmem_arbiter_if bus ();
   dmem_arbiter_if sat_bus ();

   dmem_arbiter dut (.clk(clk), .reset(reset), .bus(bus), .stall_cnt(stall_cnt));
   dmem_arbiter #(.CNT_W(4)) sat_dut (.clk(clk), .reset(sreset), .bus(sat_bus), .stall_cnt(sat_cnt));

   function automatic logic [31:0] init_word(input logic [8:0] a);
      return (a == 9'h005) ? 32'hDEADBEEF : (32'hA5A5_0000 | {23'h0, a});
   endfunction

   logic [31:0] mem [512];
   bit written [512];

   always @(posedge clk) begin
      if (bus.mem_wr) begin
         mem[bus.mem_addr] <= bus.mem_wr_data;
         written[bus.mem_addr] <= 1'b1;
      end
      bus.mem_rd_data <= bus.mem_rd ? (written[bus.mem_addr] ? mem[bus.mem_addr] : init_word(bus.mem_addr))
                                    : 32'hBAD0BAD0;
   end

   typedef struct {logic c; logic l; logic [31:0] d;} rexp_t;
   rexp_t sb[$];
   logic [31:0] shadow [512];
   int exp_stall = 0;
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One arbitration cycle: compare read return against the scoreboard, then grants and memory drive
   task automatic step(input string tag, input logic gc, input logic gl);
      rexp_t e;
      logic [8:0] a;
      logic [31:0] wd;
      logic wr, rd;
      @(negedge clk);
      e = '{1'b0, 1'b0, 32'h0};
      if (sb.size() > 0) e = sb.pop_front();
      check({tag, ".core_rvalid"}, 32'(bus.core_rvalid), 32'(e.c));
      check({tag, ".ld_rvalid"}, 32'(bus.ld_rvalid), 32'(e.l));
      check({tag, ".core_rdata"}, bus.core_rdata, e.c ? e.d : 32'h0);
      check({tag, ".ld_rdata"}, bus.ld_rdata, e.l ? e.d : 32'h0);
      check({tag, ".core_gnt"}, 32'(bus.core_gnt), 32'(gc));
      check({tag, ".ld_gnt"}, 32'(bus.ld_gnt), 32'(gl));
      check({tag, ".core_stall"}, 32'(bus.core_stall), 32'(bus.core_req & ~gc));
      check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
      a  = gc ? bus.core_addr : gl ? bus.ld_addr : 9'h0;
      wd = gc ? bus.core_wdata : gl ? bus.ld_wdata : 32'h0;
      wr = (gc & bus.core_we) | (gl & bus.ld_we);
      rd = (gc | gl) & ~wr;
      check({tag, ".mem_wr"}, 32'(bus.mem_wr), 32'(wr));
      check({tag, ".mem_rd"}, 32'(bus.mem_rd), 32'(rd));
      check({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(a));
      check({tag, ".mem_wr_data"}, bus.mem_wr_data, wd);
      if (rd) sb.push_back('{gc, gl, shadow[a]});
      if (wr) shadow[a] = wd;
      if (reset) exp_stall = 0;
      else if (bus.core_req && !gc && exp_stall < 65535) exp_stall++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 512; i++) shadow[i] = init_word(9'(i));
      bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
      bus.ld_req = 1'b0; bus.ld_we = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0; bus.ld_lock = 1'b0;
      sat_bus.core_req = 1'b1; sat_bus.core_we = 1'b1; sat_bus.core_addr = '0; sat_bus.core_wdata = '0;
      sat_bus.ld_req = 1'b1; sat_bus.ld_we = 1'b1; sat_bus.ld_addr = '0; sat_bus.ld_wdata = '0;
      sat_bus.ld_lock = 1'b1; sat_bus.mem_rd_data = '0;
      repeat (2) @(posedge clk);
      #1;
      step("rst", 1'b0, 1'b0);
      reset = 1'b0;
      // Tie after reset: core wins first, then alternation on continued ties
      bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 9'h010; bus.core_wdata = 32'd1;
      bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 9'h011; bus.ld_wdata = 32'd2;
      step("tie0", 1'b1, 1'b0);
      bus.core_addr = 9'h012; bus.core_wdata = 32'd3;
      step("tie1", 1'b0, 1'b1);
      bus.ld_addr = 9'h013; bus.ld_wdata = 32'd4;
      step("tie2", 1'b1, 1'b0);
      bus.core_req = 1'b0;
      step("tie3", 1'b0, 1'b1);
      bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 9'h010;
      bus.ld_we = 1'b0; bus.ld_addr = 9'h011;
      step("rb0", 1'b1, 1'b0);
      bus.core_addr = 9'h012;
      step("rb1", 1'b0, 1'b1);
      bus.ld_addr = 9'h013;
      step("rb2", 1'b1, 1'b0);
      bus.core_req = 1'b0;
      step("rb3", 1'b0, 1'b1);
      bus.ld_req = 1'b0;
      step("rb_drain", 1'b0, 1'b0);
      // Core-only read of the preloaded word
      bus.core_req = 1'b1; bus.core_addr = 9'h005;
      step("core_rd", 1'b1, 1'b0);
      bus.core_req = 1'b0;
      step("core_rd_ret", 1'b0, 1'b0);
      // Alternating reads from both sides
      bus.core_req = 1'b1; bus.core_addr = 9'h001;
      bus.ld_req = 1'b1; bus.ld_addr = 9'h002;
      for (int i = 0; i < 4; i++) step("alt", i[0], ~i[0]);
      bus.core_req = 1'b0; bus.ld_req = 1'b0;
      step("alt_drain", 1'b0, 1'b0);
      // Lock burst of four loader writes with the core held off
      bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 9'h020; bus.core_wdata = 32'h55;
      bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_lock = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.ld_addr = 9'(9'h030 + i); bus.ld_wdata = 32'(32'h100 + i);
         step("lock", 1'b0, 1'b1);
      end
      bus.ld_lock = 1'b0; bus.ld_addr = 9'h034; bus.ld_wdata = 32'h104;
      step("unlock", 1'b1, 1'b0);
      bus.core_req = 1'b0;
      step("unlock_ld", 1'b0, 1'b1);
      bus.ld_req = 1'b0;
      step("lock_idle", 1'b0, 1'b0);
      bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 9'h020;
      step("lock_rb_core", 1'b1, 1'b0);
      bus.core_req = 1'b0; bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 9'h033;
      step("lock_rb_ld", 1'b0, 1'b1);
      bus.ld_req = 1'b0;
      step("lock_rb_ret", 1'b0, 1'b0);
      // Reset one cycle after a granted core read
      bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 9'h005;
      step("pre_rst_rd", 1'b1, 1'b0);
      reset = 1'b1;
      sb.delete();
      exp_stall = 0;
      bus.core_we = 1'b1; bus.core_addr = 9'h040; bus.core_wdata = 32'd7;
      bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 9'h041; bus.ld_wdata = 32'd8; bus.ld_lock = 1'b1;
      step("rst_mid", 1'b0, 1'b0);
      reset = 1'b0;
      // Lock raised together with a tie the core wins: no lock entry
      step("rst_tie", 1'b1, 1'b0);
      bus.core_addr = 9'h042; bus.core_wdata = 32'd9; bus.ld_req = 1'b0;
      step("lock_noreq0", 1'b1, 1'b0);
      step("lock_noreq1", 1'b1, 1'b0);
      bus.core_req = 1'b0; bus.ld_lock = 1'b0;
      step("final_idle", 1'b0, 1'b0);
      // Narrow counter: locked loader stalls the core every cycle after the first
      sreset = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("sat.mid", 32'(sat_cnt), 32'd9);
      repeat (15) @(posedge clk);
      @(negedge clk);
      check("sat.max", 32'(sat_cnt), 32'd15);
      check("sat.core_gnt", 32'(sat_bus.core_gnt), 32'd0);
      check("sat.ld_gnt", 32'(sat_bus.ld_gnt), 32'd1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the core's single data memory (512 words, 9-bit word address) between the processor's load/store path and a loader/debug requester. It sits between the datapath's data-memory interface and the memory macro: it issues one access per cycle, routes the 1-cycle-latency read data back to whichever side issued the read, and supplies a stall to the pipeline whenever the core loses arbitration. A lock mode lets the loader own the memory for bursts, and a saturating counter records core stall cycles for performance debug.

## Interface
Parameters:
- DATA_W, 32, data word width
- ADDR_W, 9, memory word address width
- CNT_W, 16, width of stall counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- core_req  in  1  core access request, held until granted
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  core word address
- core_wdata  in  DATA_W  core write data
- core_gnt  out  1  core request accepted this cycle
- core_rvalid  out  1  core read data valid (cycle after granted read)
- core_rdata  out  DATA_W  core read data
- core_stall  out  1  core_req & ~core_gnt
- ld_req, ld_we, ld_addr, ld_wdata  in  1/1/ADDR_W/DATA_W  loader request, same rules as core
- ld_lock  in  1  loader requests exclusive ownership
- ld_gnt, ld_rvalid, ld_rdata  out  1/1/DATA_W  loader grant and read return
- mem_wr, mem_rd  out  1  memory write / read strobe
- mem_addr  out  ADDR_W  memory address
- mem_wr_data  out  DATA_W  memory write data
- mem_rd_data  in  DATA_W  memory read data, valid one cycle after mem_rd
- stall_cnt  out  CNT_W  saturating count of core_stall cycles

## Operation
- Handshake: a request is accepted in the cycle req & gnt are both 1; requester holds req/we/addr/wdata stable until then. Grants are combinational from req and registered state; at most one grant per cycle.
- State machine, states RR and LOCK. Reset state RR.
- RR: only one requester -> it is granted. Both -> the one not in register last_gnt wins; last_gnt updates to the winner on every grant. last_gnt resets to LOADER, so the core wins the first tie.
- RR -> LOCK when ld_gnt & ld_lock. LOCK: core_gnt forced 0; ld_gnt = ld_req. LOCK -> RR on the first cycle ld_lock = 0 (that cycle is already arbitrated as RR).
- Memory drive: mem_addr/mem_wr_data from the granted side; mem_wr = gnt & we; mem_rd = gnt & ~we; with no grant, mem_wr = mem_rd = 0 and mem_addr/mem_wr_data = 0.
- Read return: registered owner tag rd_owner {NONE, CORE, LD} set on each granted read. Next cycle the tagged side gets rvalid = 1 and rdata = mem_rd_data; the other side's rdata = 0. Back-to-back reads from alternating sides return in issue order.
- stall_cnt increments each cycle core_stall = 1; holds at 2^CNT_W−1.

## Timing
- Grant: 0 cycles (same-cycle combinational). Write completes at the edge ending the grant cycle. Read data: rvalid exactly 1 cycle after grant.
- Throughput: one access per cycle; no bubble on requester switch.
- Reset (async, any time): state RR, last_gnt LOADER, rd_owner NONE, stall_cnt 0; while reset high, all gnt, rvalid, mem_wr, mem_rd = 0, rdata = 0. A read granted in the cycle before reset asserts returns no rvalid.
- Simultaneous ld_lock rise and core win of the tie: core granted, no LOCK entry; LOCK only entered on a loader grant.
- ld_lock high with ld_req low in RR: no state change.

## Test plan
- Core only: read addr 0x005 holding 0xDEADBEEF -> core_gnt same cycle, mem_rd = 1, mem_addr = 0x005; next cycle core_rvalid = 1, core_rdata = 0xDEADBEEF, ld_rvalid = 0.
- Tie after reset: both req writes (core 0x010 = 1, ld 0x011 = 2) held -> cycle 0 core granted, cycle 1 loader; then alternate on continued ties; memory holds 1 and 2.
- Lock burst: loader granted with ld_lock = 1 for 4 writes while core_req held -> core_stall = 1 for 4 cycles, stall_cnt = 4; core granted in the cycle ld_lock drops.
- Alternating reads core@0x001, ld@0x002 -> rvalid/rdata routed to correct side each cycle, no cross-talk.
- Reset mid-read: assert reset one cycle after a granted core read -> no core_rvalid, all outputs 0, stall_cnt 0, next tie granted to core.
- Saturation with CNT_W = 4: 20 stall cycles -> stall_cnt stops at 15.
